// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - memory-mapped down-counting timer with prescaler, auto-reload and sticky expiry flag
module mmio_timer #(
    parameter logic [8:0] BASE     = 9'h180,
    parameter int         PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        rd_sel,
    output logic        expired
);
    localparam logic [7:0] PS_MAX = 8'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q;
    logic        en_q;
    logic        reload_q;
    logic [15:0] period_q;
    logic [15:0] count_q;
    logic        exp_q;
    logic [7:0]  presc_q;

    logic        hit;
    logic        wr;
    logic        ctrl_wr;
    logic        tick;
    logic        expire;
    logic [7:0]  presc_d;
    logic [15:0] count_d;

    assign hit     = (mem_addr[8:2] == BASE[8:2]);
    assign wr      = (mem_cmd == 2'b11) && hit;
    assign rd_sel  = (mem_cmd == 2'b10) && hit;
    assign ctrl_wr = wr && (mem_addr[1:0] == 2'd0);
    assign tick    = (state_q == RUN) && (presc_q == PS_MAX);
    // A CTRL write in the same cycle overrides whatever the tick would have done.
    assign expire  = tick && (count_q == 16'd0) && !ctrl_wr;
    assign presc_d = (presc_q == PS_MAX) ? 8'd0 : presc_q + 8'd1;
    assign count_d = (count_q != 16'd0) ? count_q - 16'd1
                   : (reload_q ? period_q : 16'd0);
    assign expired = exp_q;

    always_comb begin
        read_data = 16'b0;
        if (rd_sel) begin
            case (mem_addr[1:0])
                2'd0:    read_data = {14'b0, reload_q, en_q};
                2'd1:    read_data = period_q;
                2'd2:    read_data = count_q;
                default: read_data = {15'b0, exp_q};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            reload_q <= 1'b0;
            period_q <= 16'h0000;
            count_q  <= 16'h0000;
            exp_q    <= 1'b0;
            presc_q  <= 8'd0;
        end else begin
            if (ctrl_wr) begin
                en_q     <= write_data[0];
                reload_q <= write_data[1];
                if (write_data[0]) begin
                    count_q <= period_q;
                    presc_q <= 8'd0;
                    state_q <= RUN;
                end else begin
                    state_q <= IDLE;
                end
            end else if (state_q == RUN) begin
                presc_q <= presc_d;
                if (tick) begin
                    count_q <= count_d;
                    if (count_q == 16'd0 && !reload_q) begin
                        state_q <= DONE;
                    end
                end
            end

            if (wr && mem_addr[1:0] == 2'd1) begin
                period_q <= write_data;
            end

            if (expire) begin
                exp_q <= 1'b1;
            end else if (wr && mem_addr[1:0] == 2'd3 && write_data[0]) begin
                exp_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mmio_timer.sv
// tb/tb_mmio_timer.sv - directed scoreboard bench for mmio_timer
module tb_mmio_timer;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        rd_sel;
    logic        expired;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] sb[$];

    localparam logic [8:0] A_CTRL = 9'h180;
    localparam logic [8:0] A_PER  = 9'h181;
    localparam logic [8:0] A_CNT  = 9'h182;
    localparam logic [8:0] A_STAT = 9'h183;

    mmio_timer #(.BASE(9'h180), .PRESCALE(4)) dut (
        .clk(clk),
        .reset(reset),
        .mem_cmd(mem_cmd),
        .mem_addr(mem_addr),
        .write_data(write_data),
        .read_data(read_data),
        .rd_sel(rd_sel),
        .expired(expired)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        if (sb.size() == 0) begin
            e = 16'hxxxx;
        end else begin
            e = sb.pop_front();
        end
        n_cmp++;
        assert (obs === e) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [8:0] a, input logic [15:0] d);
        mem_cmd    = 2'b11;
        mem_addr   = a;
        write_data = d;
        @(posedge clk);
        #1;
        mem_cmd    = 2'b00;
    endtask

    task automatic rd(input logic [8:0] a, input string tag, input logic [15:0] e);
        sb.push_back(e);
        mem_cmd  = 2'b10;
        mem_addr = a;
        #1;
        check(tag, read_data);
        mem_cmd  = 2'b00;
    endtask

    task automatic ex(input string tag, input logic e);
        sb.push_back({15'b0, e});
        check(tag, {15'b0, expired});
    endtask

    initial begin
        reset      = 1'b1;
        mem_cmd    = 2'b00;
        mem_addr   = 9'h000;
        write_data = 16'h0000;
        cyc(2);
        reset = 1'b0;

        rd(A_CTRL, "rst_ctrl", 16'h0000);
        rd(A_PER,  "rst_period", 16'h0000);
        rd(A_CNT,  "rst_count", 16'h0000);
        rd(A_STAT, "rst_status", 16'h0000);
        ex("rst_expired", 1'b0);

        // one-shot: PERIOD=3, EXP exactly 16 cycles after the CTRL edge
        wr(A_PER, 16'd3);
        wr(A_CTRL, 16'd1);
        rd(A_CNT, "os_cnt3", 16'd3);
        cyc(4); rd(A_CNT, "os_cnt2", 16'd2);
        cyc(4); rd(A_CNT, "os_cnt1", 16'd1);
        cyc(4); rd(A_CNT, "os_cnt0", 16'd0);
        ex("os_exp_e12", 1'b0);
        cyc(3); ex("os_exp_e15", 1'b0);
        cyc(1); ex("os_exp_e16", 1'b1);
        rd(A_STAT, "os_status", 16'd1);
        cyc(9); rd(A_CNT, "os_done_cnt", 16'd0);
        ex("os_done_exp", 1'b1);
        rd(A_CTRL, "os_ctrl", 16'd1);
        wr(A_STAT, 16'd1);
        ex("os_clear", 1'b0);

        // auto-reload PERIOD=2: expiry every 12 cycles
        wr(A_PER, 16'd2);
        wr(A_CTRL, 16'd3);
        cyc(11); ex("rl_e11", 1'b0);
        cyc(1);  ex("rl_e12", 1'b1);
        rd(A_CNT, "rl_reloaded", 16'd2);
        wr(A_STAT, 16'd1);
        ex("rl_cleared", 1'b0);
        cyc(10); ex("rl_e23", 1'b0);
        cyc(1);  ex("rl_e24", 1'b1);
        // clear on the exact expiry edge: expiry wins
        cyc(11);
        wr(A_STAT, 16'd1);
        ex("race_exp_wins", 1'b1);
        wr(A_STAT, 16'd1);
        ex("race_clear_after", 1'b0);

        // restart on a tick edge (E40): reload, no decrement
        wr(A_PER, 16'd5);
        cyc(1);
        wr(A_CTRL, 16'd3);
        rd(A_CNT, "restart_cnt", 16'd5);
        // PERIOD change during run leaves COUNT alone
        wr(A_PER, 16'd9);
        rd(A_CNT, "per_wr_cnt", 16'd5);
        rd(A_PER, "per_rd", 16'd9);
        cyc(3); rd(A_CNT, "run_cnt4", 16'd4);
        cyc(4); rd(A_CNT, "run_cnt3", 16'd3);
        cyc(12); rd(A_CNT, "run_cnt0", 16'd0);
        cyc(4); rd(A_CNT, "reload9", 16'd9);
        ex("reload9_exp", 1'b1);
        wr(A_STAT, 16'd1);
        cyc(27); rd(A_CNT, "run_cnt2", 16'd2);
        wr(A_CTRL, 16'd0);
        ex("stop_exp", 1'b0);
        cyc(20); rd(A_CNT, "stop_hold", 16'd2);
        ex("stop_exp_hold", 1'b0);

        // decode: outside window, write command, valid read
        sb.push_back(16'd0);
        mem_cmd = 2'b10; mem_addr = 9'h184; #1;
        check("dec_oob_sel", {15'b0, rd_sel});
        sb.push_back(16'd0);
        check("dec_oob_data", read_data);
        sb.push_back(16'd0);
        mem_cmd = 2'b11; mem_addr = A_CTRL; write_data = 16'd0; #1;
        check("dec_wcmd_sel", {15'b0, rd_sel});
        sb.push_back(16'd0);
        check("dec_wcmd_data", read_data);
        sb.push_back(16'd1);
        mem_cmd = 2'b10; mem_addr = A_CNT; #1;
        check("dec_cnt_sel", {15'b0, rd_sel});
        sb.push_back(16'd2);
        check("dec_cnt_data", read_data);
        mem_cmd = 2'b00;

        // PERIOD=0 with reload: expiry on every tick
        cyc(1);
        wr(A_PER, 16'd0);
        wr(A_CTRL, 16'd3);
        cyc(3); ex("p0_e3", 1'b0);
        cyc(1); ex("p0_e4", 1'b1);
        wr(A_STAT, 16'd1);
        ex("p0_clear", 1'b0);
        cyc(2); ex("p0_e7", 1'b0);
        cyc(1); ex("p0_e8", 1'b1);

        // reset mid-run with COUNT=7, EXP=1; write in reset cycle discarded
        wr(A_PER, 16'd7);
        wr(A_CTRL, 16'd1);
        rd(A_CNT, "mid_cnt7", 16'd7);
        ex("mid_exp", 1'b1);
        reset = 1'b1;
        wr(A_PER, 16'h0055);
        reset = 1'b0;
        ex("rs_expired", 1'b0);
        rd(A_CTRL, "rs_ctrl", 16'd0);
        rd(A_PER,  "rs_period", 16'd0);
        rd(A_CNT,  "rs_count", 16'd0);
        rd(A_STAT, "rs_status", 16'd0);
        cyc(10);
        rd(A_CNT, "rs_idle_cnt", 16'd0);
        ex("rs_idle_exp", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
